// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register IDs, stop codes, control FSM states.
// Constants only; no logic, latency or backpressure of its own.
package y86_pkg;

   localparam logic [3:0] IC_HALT  = 4'h0;
   localparam logic [3:0] IC_NOP   = 4'h1;
   localparam logic [3:0] IC_CMOV  = 4'h2;
   localparam logic [3:0] IC_IRMOV = 4'h3;
   localparam logic [3:0] IC_RMMOV = 4'h4;
   localparam logic [3:0] IC_MRMOV = 4'h5;
   localparam logic [3:0] IC_OPQ   = 4'h6;
   localparam logic [3:0] IC_JXX   = 4'h7;
   localparam logic [3:0] IC_CALL  = 4'h8;
   localparam logic [3:0] IC_RET   = 4'h9;
   localparam logic [3:0] IC_PUSH  = 4'hA;
   localparam logic [3:0] IC_POP   = 4'hB;

   localparam logic [3:0] NOREG_ID = 4'hF;

   localparam logic [1:0] STOP_NONE = 2'd0;
   localparam logic [1:0] STOP_HLT  = 2'd1;
   localparam logic [1:0] STOP_INS  = 2'd2;
   localparam logic [1:0] STOP_ADR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // A bad address outranks a bad instruction, which outranks a plain hlt.
   function automatic logic [1:0] stop_encode(input logic hlt, input logic in_inst,
                                              input logic in_mem);
      if (in_mem)
         return STOP_ADR;
      else if (in_inst)
         return STOP_INS;
      else if (hlt)
         return STOP_HLT;
      else
         return STOP_NONE;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: one cycle from inc/clear to cnt; no backpressure.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble steering, IDLE/RUN/HALT sequencing, perf counters.
// Latency: controls are combinational same-cycle; state, stop_code, counters update on the edge; no backpressure.
module pipe_hazard_ctrl
   import y86_pkg::*;
#(
   parameter int         CNT_W = 32,
   parameter logic [3:0] NOREG = NOREG_ID
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic             m_hlt,
   input  logic             m_in_inst,
   input  logic             m_in_mem,
   input  logic             W_hlt,
   input  logic             W_in_inst,
   input  logic             W_in_mem,
   input  logic [3:0]       W_icode,
   output logic             F_stall,
   output logic             D_stall,
   output logic             W_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             set_cc_en,
   output logic             halted,
   output logic [1:0]       stop_code,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] rt_cnt
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] stop_code_nxt;

   logic lu;
   logic mp;
   logic rt;
   logic w_exc;
   logic mx;
   logic in_run;
   logic retire;

   assign lu = ((E_icode == IC_MRMOV) || (E_icode == IC_POP)) && (E_dstM != NOREG) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign mp     = (E_icode == IC_JXX) && !e_Cnd;
   assign rt     = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
   assign w_exc  = W_hlt || W_in_inst || W_in_mem;
   assign mx     = m_hlt || m_in_inst || m_in_mem || w_exc;
   assign in_run = (state == ST_RUN);
   assign retire = in_run && !w_exc && (W_icode != IC_HALT) && (W_icode != IC_NOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         stop_code <= STOP_NONE;
      end else begin
         state     <= state_nxt;
         stop_code <= stop_code_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stop_code_nxt = stop_code;
      F_stall       = 1'b0;
      D_stall       = 1'b0;
      W_stall       = 1'b0;
      D_bubble      = 1'b0;
      E_bubble      = 1'b0;
      M_bubble      = 1'b0;
      set_cc_en     = 1'b0;
      halted        = 1'b0;
      case (state)
         ST_IDLE: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            if (start)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Load/use holds D, so it must suppress the ret bubble into D.
            F_stall   = lu || rt;
            D_stall   = lu;
            D_bubble  = mp || (rt && !lu);
            E_bubble  = mp || lu;
            M_bubble  = mx;
            W_stall   = w_exc;
            set_cc_en = !mx;
            if (w_exc) begin
               state_nxt     = ST_HALT;
               stop_code_nxt = stop_encode(W_hlt, W_in_inst, W_in_mem);
            end
         end
         ST_HALT: begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk(clk), .rst_n(rst_n), .inc(in_run), .clear(1'b0), .cnt(cyc_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
      .clk(clk), .rst_n(rst_n), .inc(retire), .clear(1'b0), .cnt(ret_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
      .clk(clk), .rst_n(rst_n), .inc(in_run && lu), .clear(1'b0), .cnt(lu_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
      .clk(clk), .rst_n(rst_n), .inc(in_run && mp), .clear(1'b0), .cnt(mp_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_rt_cnt (
      .clk(clk), .rst_n(rst_n), .inc(in_run && rt && !lu), .clear(1'b0), .cnt(rt_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: a 32-bit and a 4-bit counter instance share stimulus
// and are compared every cycle against a rule-level model of the control unit.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
   logic       e_Cnd;
   logic       m_hlt, m_in_inst, m_in_mem, W_hlt, W_in_inst, W_in_mem;

   logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc_en, halted;
   logic [1:0]  stop_code;
   logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rt_cnt;

   logic        s_F_stall, s_D_stall, s_W_stall, s_D_bubble, s_E_bubble, s_M_bubble;
   logic        s_set_cc_en, s_halted;
   logic [1:0]  s_stop_code;
   logic [3:0]  s_cyc, s_ret, s_lu, s_mp, s_rt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(32), .NOREG(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_hlt(m_hlt), .m_in_inst(m_in_inst), .m_in_mem(m_in_mem),
      .W_hlt(W_hlt), .W_in_inst(W_in_inst), .W_in_mem(W_in_mem), .W_icode(W_icode),
      .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
      .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
      .set_cc_en(set_cc_en), .halted(halted), .stop_code(stop_code),
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .rt_cnt(rt_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(4), .NOREG(4'hF)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_hlt(m_hlt), .m_in_inst(m_in_inst), .m_in_mem(m_in_mem),
      .W_hlt(W_hlt), .W_in_inst(W_in_inst), .W_in_mem(W_in_mem), .W_icode(W_icode),
      .F_stall(s_F_stall), .D_stall(s_D_stall), .W_stall(s_W_stall),
      .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble),
      .set_cc_en(s_set_cc_en), .halted(s_halted), .stop_code(s_stop_code),
      .cyc_cnt(s_cyc), .ret_cnt(s_ret), .lu_cnt(s_lu), .mp_cnt(s_mp), .rt_cnt(s_rt)
   );

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Reference model: phase 0 idle, 1 running, 2 halted; counts kept unbounded.
   int     m_phase;
   int     m_stop;
   longint m_cyc, m_ret, m_lu, m_mp, m_rt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint top;
      top = (longint'(1) << w) - 1;
      return (v > top) ? top : v;
   endfunction

   function automatic bit t_lu();
      return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
   endfunction

   function automatic bit t_mp();
      return E_icode == 4'h7 && e_Cnd == 1'b0;
   endfunction

   function automatic bit t_rt();
      return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
   endfunction

   function automatic bit t_wx();
      return W_hlt || W_in_inst || W_in_mem;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_stop  = 0;
      m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0; m_rt = 0;
   endtask

   task automatic model_edge();
      bit lu, mp, rt, wx;
      lu = t_lu(); mp = t_mp(); rt = t_rt(); wx = t_wx();
      if (m_phase == 1) begin
         m_cyc++;
         if (!wx && W_icode != 4'h0 && W_icode != 4'h1) m_ret++;
         if (lu) m_lu++;
         if (mp) m_mp++;
         if (rt && !lu) m_rt++;
         if (wx) begin
            m_phase = 2;
            m_stop  = W_in_mem ? 3 : (W_in_inst ? 2 : 1);
         end
      end else if (m_phase == 0 && start) begin
         m_phase = 1;
      end
   endtask

   task automatic check_all();
      bit lu, mp, rt, wx, mx;
      bit fs, ds, ws, db, eb, mb, cc;
      lu = t_lu(); mp = t_mp(); rt = t_rt(); wx = t_wx();
      mx = wx || m_hlt || m_in_inst || m_in_mem;
      case (m_phase)
         0: begin fs = 1; ds = 0; ws = 0; db = 1; eb = 1; mb = 1; cc = 0; end
         1: begin fs = lu | rt; ds = lu; ws = wx; db = mp | (rt & ~lu); eb = mp | lu;
                  mb = mx; cc = ~mx; end
         default: begin fs = 1; ds = 1; ws = 1; db = 0; eb = 0; mb = 0; cc = 0; end
      endcase
      check("F_stall", F_stall, fs);
      check("D_stall", D_stall, ds);
      check("W_stall", W_stall, ws);
      check("D_bubble", D_bubble, db);
      check("E_bubble", E_bubble, eb);
      check("M_bubble", M_bubble, mb);
      check("set_cc_en", set_cc_en, cc);
      check("D_excl", D_stall & D_bubble, 0);
      check("halted", halted, m_phase == 2);
      check("stop_code", stop_code, m_stop);
      check("cyc_cnt", cyc_cnt, sat(m_cyc, 32));
      check("ret_cnt", ret_cnt, sat(m_ret, 32));
      check("lu_cnt", lu_cnt, sat(m_lu, 32));
      check("mp_cnt", mp_cnt, sat(m_mp, 32));
      check("rt_cnt", rt_cnt, sat(m_rt, 32));
      check("s_cyc", s_cyc, sat(m_cyc, 4));
      check("s_ret", s_ret, sat(m_ret, 4));
      check("s_lu", s_lu, sat(m_lu, 4));
      check("s_mp", s_mp, sat(m_mp, 4));
      check("s_rt", s_rt, sat(m_rt, 4));
      check("s_halted", s_halted, m_phase == 2);
      check("s_F_stall", s_F_stall, fs);
   endtask

   // Called just after a falling edge with inputs already set.
   task automatic step();
      #1 check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic quiet();
      start = 0;
      D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
      m_hlt = 0; m_in_inst = 0; m_in_mem = 0;
      W_hlt = 0; W_in_inst = 0; W_in_mem = 0;
   endtask

   task automatic reset_seq();
      rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] rand_reg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 4'hF : 4'(r);
   endfunction

   function automatic bit rare(input int per_mille);
      return $urandom_range(0, 999) < per_mille;
   endfunction

   task automatic rand_vec(input int per_mille);
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      W_icode = 4'($urandom_range(0, 11));
      d_srcA  = rand_reg();
      d_srcB  = rand_reg();
      E_dstM  = rand_reg();
      e_Cnd   = 1'($urandom_range(0, 1));
      m_hlt = rare(per_mille * 3); m_in_inst = rare(per_mille * 3); m_in_mem = rare(per_mille * 3);
      W_hlt = rare(per_mille); W_in_inst = rare(per_mille); W_in_mem = rare(per_mille);
   endtask

   initial begin
      rst_n = 1'b0;
      quiet();
      model_reset();
      @(negedge clk);
      reset_seq();

      // Idle, then leave IDLE on a start pulse.
      for (int i = 0; i < 5; i++) step();
      start = 1; step();
      start = 0; step();

      // Load/use, then the same with E_dstM = no register.
      E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; step();
      E_dstM = 4'hF; step();
      quiet();

      // Mispredict taken/not taken.
      E_icode = 4'h7; e_Cnd = 0; step();
      e_Cnd = 1; step();
      quiet();

      // ret walking through D, E, M; then ret together with load/use.
      D_icode = 4'h9; step();
      D_icode = 4'h1; E_icode = 4'h9; step();
      E_icode = 4'h1; M_icode = 4'h9; step();
      M_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2; step();
      quiet();

      // Exception in memory, then W with two flags; halt must absorb start.
      W_icode = 4'h6; step();
      m_in_mem = 1; step();
      m_in_mem = 0; W_in_mem = 1; W_hlt = 1; step();
      quiet();
      W_icode = 4'h6;
      start = 1;
      for (int i = 0; i < 3; i++) step();
      quiet();

      // Randomized episodes, some cut short by a mid-run reset.
      for (int ep = 0; ep < 10; ep++) begin
         reset_seq();
         for (int i = 0; i < 3; i++) begin rand_vec(0); start = 0; step(); end
         start = 1; rand_vec(0); step();
         start = 0;
         for (int i = 0; i < 160; i++) begin
            if ((ep % 3) == 1 && i == 40) begin
               rand_vec(0);
               reset_seq();
               break;
            end
            rand_vec(ep < 5 ? 2 : 8);
            start = 1'($urandom_range(0, 7) == 0);
            step();
         end
         for (int i = 0; i < 4; i++) begin
            rand_vec(0);
            start = 1'($urandom_range(0, 1));
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
